// File: rtl/pdm_tx.sv
// pdm_tx: first-order delta-sigma PDM transmitter; 8-bit PCM in via valid/ready FIFO, outputs pdm_clk_o/pdm_o/aud_sd_o plus underrun_o and fifo_level_o
module pdm_tx #(
  parameter int CLK_DIV    = 32,
  parameter int OSR        = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [7:0]                       sample_i,
  input  logic                             sample_valid_i,
  output logic                             sample_ready_o,
  input  logic                             en_i,
  output logic                             pdm_clk_o,
  output logic                             pdm_o,
  output logic                             aud_sd_o,
  output logic                             underrun_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [DW-1:0] div_cnt, div_cnt_nx;
  logic [BW-1:0] bit_cnt;
  logic [7:0] acc, cur_sample;
  logic [8:0] sum;
  logic empty, push, pop, bit_tick, last_bit, run_nx;
  always_comb begin
    empty          = fifo_level_o == '0;
    sample_ready_o = fifo_level_o != LW'(FIFO_DEPTH);
    push           = sample_valid_i && sample_ready_o;
    bit_tick       = state == RUN && div_cnt == DW'(CLK_DIV - 1);
    last_bit       = bit_tick && bit_cnt == BW'(OSR - 1);
    pop            = en_i && !empty && (state == IDLE || last_bit);
    state_nx       = state == IDLE ? ((en_i && !empty) ? RUN : IDLE) : (en_i ? RUN : IDLE);
    run_nx         = state_nx == RUN;
    div_cnt_nx     = (state == IDLE || bit_tick) ? '0 : div_cnt + DW'(1);
    sum            = {1'b0, acc} + {1'b0, cur_sample};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_level_o <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      acc          <= '0;
      cur_sample   <= '0;
      pdm_clk_o    <= 1'b0;
      pdm_o        <= 1'b0;
      aud_sd_o     <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      state        <= state_nx;
      if (push) mem[wr_ptr] <= sample_i;
      wr_ptr       <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_level_o <= fifo_level_o + LW'(push) - LW'(pop);
      aud_sd_o     <= run_nx;
      div_cnt      <= run_nx ? div_cnt_nx : '0;
      pdm_clk_o    <= run_nx && div_cnt_nx >= DW'(CLK_DIV / 2);
      underrun_o   <= run_nx && last_bit && empty;
      if (!run_nx) begin
        bit_cnt <= '0;
        acc     <= '0;
        pdm_o   <= 1'b0;
      end else if (state == IDLE) begin
        bit_cnt    <= '0;
        acc        <= '0;
        pdm_o      <= 1'b0;
        cur_sample <= mem[rd_ptr];
      end else if (bit_tick) begin
        pdm_o   <= sum[8];
        acc     <= sum[7:0];
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
        if (last_bit) cur_sample <= empty ? 8'h80 : mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_pdm_tx.sv
// tb_pdm_tx: randomized self-checking bench for pdm_tx against a cumulative-sum density model
module tb_pdm_tx;
  logic clk = 0, rst_ni = 0;
  logic [7:0] sample_i = 0;
  logic sample_valid_i = 0, en_i = 0;
  logic sample_ready_o, pdm_clk_o, pdm_o, aud_sd_o, underrun_o;
  logic [2:0] fifo_level_o;
  int errors = 0, checks = 0;
  int mq[$];
  int win_ones[$];
  int bits[$];
  int cur, cum, rel, ones, nunder;
  int push_at = -1, push_val = 0;
  pdm_tx dut (
    .clk_i(clk), .rst_ni(rst_ni), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .en_i(en_i), .pdm_clk_o(pdm_clk_o), .pdm_o(pdm_o),
    .aud_sd_o(aud_sd_o), .underrun_o(underrun_o), .fifo_level_o(fifo_level_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int v);
    sample_i = v[7:0];
    sample_valid_i = 1;
    if (sample_ready_o) mq.push_back(v);
    cyc(1);
    sample_valid_i = 0;
  endtask
  task automatic idle_check(input string tag);
    check({tag, "_pdm"}, pdm_o, 0);
    check({tag, "_clk"}, pdm_clk_o, 0);
    check({tag, "_sd"}, aud_sd_o, 0);
    check({tag, "_und"}, underrun_o, 0);
  endtask
  task automatic start();
    en_i = 1;
    cyc(1);
    check("entry_sd", aud_sd_o, 1);
    check("entry_pdm", pdm_o, 0);
    check("entry_clk", pdm_clk_o, 0);
    rel = 0; cum = 0; ones = 0; nunder = 0;
    win_ones.delete();
    bits.delete();
    cur = mq.pop_front();
  endtask
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      bit took = 0;
      if (rel == push_at) begin
        sample_i = push_val[7:0];
        sample_valid_i = 1;
        took = sample_ready_o;
      end
      cyc(1);
      sample_valid_i = 0;
      rel++;
      if (rel % 32 == 0) begin
        int b = (cum + cur) / 256 - cum / 256;
        cum += cur;
        bits.push_back(b);
        ones += b;
        check("pdm_bit", pdm_o, b);
        check("clk_fall", pdm_clk_o, 0);
        if (rel % 4096 == 0) begin
          int u = (mq.size() == 0) ? 1 : 0;
          check("underrun", underrun_o, u);
          nunder += u;
          cur = u ? 128 : mq.pop_front();
          win_ones.push_back(ones);
          ones = 0;
        end else check("no_underrun", underrun_o, 0);
      end else if (rel % 32 == 16) check("clk_high", pdm_clk_o, 1);
      if (took) mq.push_back(push_val);
    end
  endtask
  initial begin
    en_i = 1; sample_valid_i = 1; sample_i = 8'h5A;
    cyc(4);
    idle_check("rst");
    check("rst_level", fifo_level_o, 0);
    check("rst_ready", sample_ready_o, 1);
    en_i = 0; sample_valid_i = 0; rst_ni = 1;
    cyc(3);
    check("post_rst_level", fifo_level_o, 0);
    check("post_rst_sd", aud_sd_o, 0);
    push(8'h80);
    check("push_level", fifo_level_o, 1);
    start();
    check("mid_level", fifo_level_o, 0);
    stream(4096 + 64);
    check("mid_ones", win_ones[0], 64);
    check("mid_bit0", bits[0], 0);
    check("mid_bit1", bits[1], 1);
    check("mid_nunder", nunder, 1);
    en_i = 0;
    cyc(1);
    idle_check("mid_stop");
    push(8'h00); push(8'h40); push(8'hFF);
    check("dens_level", fifo_level_o, 3);
    start();
    check("dens_level_run", fifo_level_o, 2);
    stream(3 * 4096);
    check("dens_w0", win_ones[0], 0);
    check("dens_w1", win_ones[1], 32);
    check("dens_w2", win_ones[2], 127);
    check("dens_ff_bit0", bits[256], 0);
    check("dens_nunder", nunder, 1);
    en_i = 0;
    cyc(1);
    idle_check("dens_stop");
    for (int i = 0; i < 5; i++) begin
      sample_i = 8'(8'h10 + i * 8'h20);
      sample_valid_i = 1;
      check("fill_ready", sample_ready_o, (i < 4) ? 1 : 0);
      if (sample_ready_o) mq.push_back(int'(sample_i));
      if (i < 4) cyc(1);
    end
    check("full_level", fifo_level_o, 4);
    start();
    sample_valid_i = 0;
    check("full_pop_level", fifo_level_o, 3);
    check("full_pop_ready", sample_ready_o, 1);
    stream(50 * 32 + 5);
    en_i = 0;
    cyc(1);
    idle_check("abort");
    check("abort_level", fifo_level_o, 3);
    start();
    check("rst_run_level", fifo_level_o, 2);
    stream(20 * 32 + 7);
    #2 rst_ni = 0;
    #1;
    idle_check("arst");
    check("arst_level", fifo_level_o, 0);
    check("arst_ready", sample_ready_o, 1);
    en_i = 0;
    mq.delete();
    cyc(2);
    rst_ni = 1;
    cyc(2);
    check("arst_rel_level", fifo_level_o, 0);
    push(8'hC0);
    start();
    push_at = 4096 + 2000;
    push_val = 8'h40;
    stream(8192 + 4096 - 200);
    push_at = -1;
    check("rec_w0", win_ones[0], 96);
    check("rec_w1", win_ones[1], 64);
    check("rec_w2_part", ones, 30);
    check("rec_nunder", nunder, 1);
    en_i = 0;
    cyc(1);
    idle_check("rec_stop");
    repeat (2) begin
      for (int i = 0; i < 3; i++) push(int'($urandom_range(0, 255)));
      start();
      stream(3 * 4096 + 40);
      check("rnd_nunder", nunder, 1);
      en_i = 0;
      cyc(1);
      idle_check("rnd_stop");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdm_tx.md
# pdm_tx

First-order delta-sigma PDM transmitter, the output-side counterpart of the microphone PDM receive path. Accepts 8-bit unsigned PCM samples over a valid/ready handshake and buffers them in a small FIFO. Each sample is oversampled into a 1-bit PDM stream with its own bit clock, which drives the board audio amplifier or a PDM loopback into the receive path.

## Interface
Parameters:
- CLK_DIV, 32, system clocks per PDM bit; even, >= 4
- OSR, 128, PDM bits per PCM sample; >= 2
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, >= 2

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_ni  in  1  asynchronous active-low reset
- sample_i  in  8  unsigned PCM sample, 0x00 = min, 0x80 = midscale
- sample_valid_i  in  1  sample_i valid
- sample_ready_o  out  1  FIFO can accept; equals (fifo_level_o != FIFO_DEPTH)
- en_i  in  1  stream enable, level-sensitive
- pdm_clk_o  out  1  PDM bit clock, registered
- pdm_o  out  1  PDM data, registered
- aud_sd_o  out  1  amplifier enable, high in RUN
- underrun_o  out  1  one-cycle pulse when a sample is due and the FIFO is empty
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

## Operation
- Clock and reset: one clock domain (clk_i). Every register resets asynchronously on rst_ni low.
- FIFO:
  - Push when sample_valid_i && sample_ready_o.
  - Pop happens only on a sample load.
  - Push and pop in the same cycle leave the level unchanged.
  - There is no bypass: when full, ready is low even if a pop occurs that cycle.
  - FIFO is written in both states.
- State machine:
  - IDLE to RUN: en_i=1 and FIFO non-empty.
  - RUN to IDLE: en_i=0, takes effect next cycle. FIFO contents are kept, and the current sample is discarded.
- IDLE:
  - div_cnt=0, bit_cnt=0, acc=0.
  - pdm_clk_o=0, pdm_o=0, aud_sd_o=0.
- RUN entry cycle:
  - Pop FIFO head into cur_sample.
  - div_cnt=0, bit_cnt=0, acc=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pdm_clk_o <= (div_cnt_next >= CLK_DIV/2).
  - bit_tick = (div_cnt == CLK_DIV-1).
- Modulator, on bit_tick:
  - sum[8:0] = {1'b0,acc} + {1'b0,cur_sample}.
  - pdm_o <= sum[8]; acc <= sum[7:0].
  - Ones density equals cur_sample/256. Starting from acc=0, k bits produce floor(k*cur_sample/256) ones.
- Sample counter: bit_cnt counts 0..OSR-1 on bit_tick. On a bit_tick with bit_cnt==OSR-1:
  - FIFO non-empty: pop into cur_sample.
  - FIFO empty: cur_sample <= 8'h80 and underrun_o pulses for that one cycle. State stays RUN.
  - acc is not cleared at sample boundaries.
- Widths: div_cnt $clog2(CLK_DIV), bit_cnt $clog2(OSR), acc 8 bits. sum is 9 bits with no saturation.

## Timing
- Reset values:
  - pdm_clk_o=0, pdm_o=0, aud_sd_o=0, underrun_o=0, fifo_level_o=0.
  - sample_ready_o=1, state=IDLE.
- Handshake:
  - sample_ready_o is combinational from the level register.
  - A push is visible in fifo_level_o one cycle after the accepting edge.
- Start latency:
  - RUN is entered one cycle after en_i=1 and non-empty are sampled.
  - aud_sd_o rises in the entry cycle.
- Bit timing:
  - First pdm_o update at the edge ending entry+CLK_DIV-1.
  - pdm_o changes coincident with pdm_clk_o falling.
  - pdm_clk_o is high for the second half of each bit, so the receiver samples mid-bit.
- Sample period: OSR*CLK_DIV clocks (4096 at defaults).
- Underrun pulse coincides with the bit_tick that would have popped.
- en_i drop: one cycle later all outputs except the FIFO are at IDLE values, mid-bit included.
- rst_ni low mid-stream: all outputs go to reset values immediately (asynchronous) and the FIFO empties. Release is synchronous to the next clk_i edge.

## Test plan
- Reset: hold rst_ni=0 with en_i=1 and valid=1 -> all outputs at reset values, sample_ready_o=1, no push counted; after release, fifo_level_o=0 until the next accepted push.
- Midscale: push 0x80, en_i=1 -> aud_sd_o=1; first 128 PDM bits read 0,1,0,1..., 64 ones; pdm_clk_o period 32 clocks; underrun_o pulses at clock 4096 after entry.
- Density: push 0x00, 0x40, 0xFF back-to-back -> ones per 128-bit window are 0, 32, 127, with the first bit of the 0xFF window 0.
- FIFO full: with en_i=0, push 5 consecutive samples -> first 4 accepted, fifo_level_o=4, sample_ready_o=0 on the 5th; assert en_i -> level 3 the cycle after RUN entry, ready=1.
- Underrun recovery: one sample, en_i held, push 0x40 2000 clocks after underrun -> midscale bits until the next boundary, then 0x40 density, no second underrun.
- Mid-operation abort: drop en_i at bit 50 -> next cycle pdm_o=0, pdm_clk_o=0, aud_sd_o=0, FIFO level unchanged; repeat with rst_ni pulse -> outputs clear asynchronously and the FIFO empties.
